// File: rtl/mem_access_if.sv
// mem_access_if: M-stage request/strobe signals and W-stage load-return signals
// shared between the pipeline and mem_access_unit.
interface mem_access_if #(parameter int DATA_W = 32);
    logic [3:0]          m_op;
    logic [31:0]         m_addr;
    logic [DATA_W-1:0]   m_rt;
    logic [1:0]          m_cmov;
    logic                stall;
    logic                flush;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_wdata;
    logic                exc_adel;
    logic                exc_ades;
    logic                m_cmov_we;
    logic [31:0]         badvaddr;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_load_result;
    logic                w_load_valid;
    logic                w_cmov_we;
    modport slave (
        input  m_op, m_addr, m_rt, m_cmov, stall, flush, w_rdata,
        output mem_we, mem_be, mem_wdata, exc_adel, exc_ades, m_cmov_we, badvaddr,
               w_load_result, w_load_valid, w_cmov_we
    );
    modport master (
        output m_op, m_addr, m_rt, m_cmov, stall, flush, w_rdata,
        input  mem_we, mem_be, mem_wdata, exc_adel, exc_ades, m_cmov_we, badvaddr,
               w_load_result, w_load_valid, w_cmov_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage byte-enable/store-data/alignment decode plus M->W load extraction.
// MEM_ALIGN_EXC_EN enables address-error exceptions; otherwise misaligned addresses are force-aligned.
module mem_access_unit #(parameter int DATA_W = 32) (
    input logic         clk,
    input logic         reset,
    mem_access_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_LWL = 4'd6, OP_LWR = 4'd7, OP_SB = 4'd8, OP_SH = 4'd9,
                           OP_SW = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12, OP_LD = 4'd13, OP_SD = 4'd14;
    logic [3:0]       op, op_d, op_q, wm;
    logic             is_load, is_store, sz_b, sz_h, sz_w, sz_d, is_l, is_r, exc, lane, we;
    logic [1:0]       off, off_q;
    logic [31:0]      wd, rt_q, badvaddr_d, badvaddr_q, w, sh, lwl, lwr;
    logic [BYTES-1:0] be;
    logic             lane_q, cmov_q;
    assign op = (bus.m_op == 4'd15 || (DATA_W == 32 && (bus.m_op == OP_LD || bus.m_op == OP_SD)))
                ? OP_NONE : bus.m_op;
    assign is_load  = op inside {[OP_LB:OP_LWR], OP_LD};
    assign is_store = op inside {[OP_SB:OP_SWR], OP_SD};
    assign sz_b = op inside {OP_LB, OP_LBU, OP_SB};
    assign sz_h = op inside {OP_LH, OP_LHU, OP_SH};
    assign sz_w = op inside {OP_LW, OP_SW};
    assign sz_d = op inside {OP_LD, OP_SD};
    assign is_l = op inside {OP_LWL, OP_SWL};
    assign is_r = op inside {OP_LWR, OP_SWR};
`ifdef MEM_ALIGN_EXC_EN
    assign exc  = (sz_h & bus.m_addr[0]) | (sz_w & |bus.m_addr[1:0]) | (sz_d & |bus.m_addr[2:0]);
    assign off  = bus.m_addr[1:0];
    assign lane = DATA_W == 64 ? bus.m_addr[2] : 1'b0;
`else
    assign exc  = 1'b0;
    assign off  = (sz_w | sz_d) ? 2'b00 : sz_h ? {bus.m_addr[1], 1'b0} : bus.m_addr[1:0];
    assign lane = (DATA_W == 64 && !sz_d) ? bus.m_addr[2] : 1'b0;
`endif
    // Word-level mask; LWL/SWL cover bytes 0..off, LWR/SWR cover bytes off..3
    assign wm = sz_b ? 4'b0001 << off :
                sz_h ? 4'b0011 << off :
                is_l ? (4'b0010 << off) - 4'd1 :
                is_r ? ~((4'b0001 << off) - 4'd1) : 4'b1111;
    assign be = sz_d ? '1 : BYTES'(wm) << {lane, 2'b00};
    assign wd = sz_b ? {4{bus.m_rt[7:0]}} :
                sz_h ? {2{bus.m_rt[15:0]}} :
                is_l ? bus.m_rt[31:0] >> {~off, 3'b000} :
                is_r ? bus.m_rt[31:0] << {off, 3'b000} : bus.m_rt[31:0];
    assign we            = is_store & ~exc & ~bus.stall & ~bus.flush;
    assign bus.mem_we    = we;
    assign bus.mem_be    = (we | (is_load & ~exc)) ? be : '0;
    assign bus.mem_wdata = sz_d ? bus.m_rt : {(BYTES / 4){wd}};
    assign bus.exc_adel  = is_load & exc;
    assign bus.exc_ades  = is_store & exc;
    assign bus.m_cmov_we = ~bus.flush & ((bus.m_cmov == 2'b01 & |bus.m_rt) | (bus.m_cmov == 2'b10 & ~|bus.m_rt));
    assign op_d       = (bus.flush | ~is_load | exc) ? OP_NONE : op;
    assign badvaddr_d = (exc & ~bus.stall & ~bus.flush) ? bus.m_addr : badvaddr_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= OP_NONE;
            off_q      <= 2'b00;
            lane_q     <= 1'b0;
            rt_q       <= '0;
            cmov_q     <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            if (bus.flush || !bus.stall) begin
                op_q   <= op_d;
                off_q  <= off;
                lane_q <= lane;
                rt_q   <= bus.m_rt[31:0];
                cmov_q <= bus.m_cmov_we;
            end
            badvaddr_q <= badvaddr_d;
        end
    end
    assign w   = 32'(bus.w_rdata >> {lane_q, 5'b00000});
    assign sh  = w >> {off_q, 3'b000};
    assign lwl = (w << {~off_q, 3'b000}) | (rt_q & ~(32'hFFFF_FFFF << {~off_q, 3'b000}));
    assign lwr = sh | (rt_q & ~(32'hFFFF_FFFF >> {off_q, 3'b000}));
    assign bus.w_load_result = op_q == OP_LB  ? DATA_W'($signed(sh[7:0])) :
                               op_q == OP_LBU ? DATA_W'(sh[7:0]) :
                               op_q == OP_LH  ? DATA_W'($signed(sh[15:0])) :
                               op_q == OP_LHU ? DATA_W'(sh[15:0]) :
                               op_q == OP_LW  ? DATA_W'($signed(w)) :
                               op_q == OP_LWL ? DATA_W'($signed(lwl)) :
                               op_q == OP_LWR ? DATA_W'($signed(lwr)) :
                               op_q == OP_LD  ? bus.w_rdata : '0;
    assign bus.w_load_valid = op_q inside {[OP_LB:OP_LWR], OP_LD};
    assign bus.w_cmov_we    = cmov_q;
    assign bus.badvaddr     = badvaddr_q;
endmodule
